// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_host_tx                                                  |
// | Description : Host-to-device PS/2 transmitter. Inhibits the bus, sends a   |
// |               start bit, 8 data bits LSB first, odd parity and a stop bit  |
// |               clocked by the device, then checks the device ACK. Lines are |
// |               driven open-drain style through low-enables only.            |
// | Options     : define PS2_TX_RETRY_EN to retry a byte once after a NACK or  |
// |               timeout before reporting err.                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_drive_low,
  output logic       PS2_data_drive_low
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 2;
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic [8:0]       frame;      // {parity, data}; index = number of edges already seen
  logic [3:0]       edge_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
`ifdef PS2_TX_RETRY_EN
  logic             retry;
`endif

  logic fall_edge;
  logic timed_out;
  logic nack;
  logic fail;

  assign fall_edge = clk_prev & ~clk_sync[1];
  // Only device-clocked phases can time out; the inhibit phase is host-driven.
  assign timed_out = (state != IDLE) && (state != INHIBIT) && !fall_edge &&
                     (tmo_cnt >= TMO_LAST);
  assign nack      = (state == ACK) && fall_edge && data_sync[1];
  assign fail      = timed_out | nack;

  // Two-flop synchronizers on both pads plus a delayed clk copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_clk_in};
      data_sync <= {data_sync[0], PS2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  // Transfer sequencer with registered handshake and line-drive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      PS2_clk_drive_low  <= 1'b0;
      PS2_data_drive_low <= 1'b0;
      frame              <= '0;
      edge_cnt           <= '0;
      inh_cnt            <= '0;
      tmo_cnt            <= '0;
`ifdef PS2_TX_RETRY_EN
      retry              <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Our own inhibit pull produces a falling edge; it must not restart the budget.
      if (state != IDLE) begin
        tmo_cnt <= (fall_edge && state != INHIBIT) ? '0 : tmo_cnt + TMO_W'(1);
      end

      case (state)
        IDLE: begin
          tx_ready           <= 1'b1;
          busy               <= 1'b0;
          PS2_clk_drive_low  <= 1'b0;
          PS2_data_drive_low <= 1'b0;
          if (tx_valid && tx_ready) begin
            frame             <= {~^tx_data, tx_data};
            tx_ready          <= 1'b0;
            busy              <= 1'b1;
            PS2_clk_drive_low <= 1'b1;
            inh_cnt           <= '0;
            tmo_cnt           <= '0;
            edge_cnt          <= '0;
`ifdef PS2_TX_RETRY_EN
            retry             <= 1'b0;
`endif
            state             <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + INH_W'(1);
          if (inh_cnt == INH_PRE) PS2_data_drive_low <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            PS2_clk_drive_low <= 1'b0;
            state             <= START;
          end
        end
        START, SHIFT: begin
          if (fall_edge) begin
            PS2_data_drive_low <= ~frame[edge_cnt];
            edge_cnt           <= edge_cnt + 4'd1;
            state              <= (edge_cnt == 4'd8) ? STOP : SHIFT;
          end
        end
        STOP: begin
          if (fall_edge) begin
            PS2_data_drive_low <= 1'b0;
            edge_cnt           <= 4'd10;
            state              <= ACK;
          end
        end
        ACK: begin
          if (fall_edge) begin
            edge_cnt <= 4'd11;
            if (!data_sync[1]) state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync[1] && data_sync[1]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Failure overrides whatever the phase logic decided this cycle.
      if (fail) begin
        done               <= 1'b0;
        edge_cnt           <= '0;
        PS2_clk_drive_low  <= 1'b0;
        PS2_data_drive_low <= 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (!retry) begin
          retry             <= 1'b1;
          PS2_clk_drive_low <= 1'b1;
          inh_cnt           <= '0;
          tmo_cnt           <= '0;
          state             <= INHIBIT;
        end else
`endif
        begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule
`default_nettype wire
